// File: rtl/rgb2hsi_pipe.sv
// rgb2hsi_pipe: 10-stage RGB to HSI converter, one pixel per clock.
// Define RGB2HSI_XY_PASS_EN to carry pixel X/Y coordinates alongside.
module rgb2hsi_pipe (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  input  logic       iDVAL,
`ifdef RGB2HSI_XY_PASS_EN
  input  logic [9:0] iX,
  input  logic [9:0] iY,
  output logic [9:0] oX,
  output logic [9:0] oY,
`endif
  output logic [8:0] oH,
  output logic [7:0] oS,
  output logic [7:0] oI,
  output logic       oDVAL
);

  typedef enum logic [1:0] {DOM_R, DOM_G, DOM_B} dom_e;
  localparam int N = 9;

  logic [7:0] mx, mn, adif;
  logic [8:0] dif;
  dom_e       dom;

  always_comb begin
    mx  = iR;
    dom = DOM_R;
    dif = {1'b0, iG} - {1'b0, iB};
    if (!(iR >= iG && iR >= iB)) begin
      if (iG >= iB) begin
        mx  = iG;
        dom = DOM_G;
        dif = {1'b0, iB} - {1'b0, iR};
      end else begin
        mx  = iB;
        dom = DOM_B;
        dif = {1'b0, iR} - {1'b0, iG};
      end
    end
    mn = iR;
    if (iG < mn) mn = iG;
    if (iB < mn) mn = iB;
    adif = dif[8] ? 8'(-dif) : dif[7:0];
  end

  logic [N-1:0] vld;
  dom_e         dm   [N];
  logic         ng   [N];
  logic         rz   [N];
  logic [7:0]   rng  [N];
  logic [13:0]  hrem [N];
  logic [5:0]   hq   [N];
  logic [9:0]   sum  [N];
  logic [17:0]  srem [N];
  logic [7:0]   sq   [N];

  logic [13:0]  hdv [1:N-1];
  logic [17:0]  sdv [1:N-1];
  logic [N-1:1] hge, sge;

  // Hue quotient bits resolve in stages 2..7, saturation in 2..9
  always_comb begin
    hge = '0;
    sge = '0;
    for (int s = 1; s < N; s++) begin
      hdv[s] = 14'(rng[s-1]) << ((s <= 6) ? 6 - s : 0);
      hge[s] = (s <= 6) && (hrem[s-1] >= hdv[s]);
      sdv[s] = 18'(sum[s-1]) << (8 - s);
      sge[s] = srem[s-1] >= sdv[s];
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) vld <= '0;
    else         vld <= {vld[N-2:0], iDVAL};
    dm[0]   <= dom;
    ng[0]   <= dif[8];
    rz[0]   <= (mx == mn);
    rng[0]  <= mx - mn;
    hrem[0] <= 14'(adif) * 14'd60;
    hq[0]   <= '0;
    sum[0]  <= 10'(iR) + 10'(iG) + 10'(iB);
    srem[0] <= 18'(mn) * 18'd765;
    sq[0]   <= '0;
    for (int s = 1; s < N; s++) begin
      dm[s]   <= dm[s-1];
      ng[s]   <= ng[s-1];
      rz[s]   <= rz[s-1];
      rng[s]  <= rng[s-1];
      sum[s]  <= sum[s-1];
      hrem[s] <= hge[s] ? hrem[s-1] - hdv[s] : hrem[s-1];
      hq[s]   <= (s <= 6) ? {hq[s-1][4:0], hge[s]} : hq[s-1];
      srem[s] <= sge[s] ? srem[s-1] - sdv[s] : srem[s-1];
      sq[s]   <= {sq[s-1][6:0], sge[s]};
    end
  end

`ifdef RGB2HSI_XY_PASS_EN
  logic [19:0] xy [N];

  always_ff @(posedge iCLK) begin
    xy[0] <= {iX, iY};
    for (int s = 1; s < N; s++) xy[s] <= xy[s-1];
  end
`endif

  logic [8:0] q, hval;
  logic [7:0] sval, ival;

  always_comb begin
    q    = {3'b0, hq[N-1]};
    hval = '0;
    unique case (dm[N-1])
      DOM_G:   hval = ng[N-1] ? 9'd120 - q : 9'd120 + q;
      DOM_B:   hval = ng[N-1] ? 9'd240 - q : 9'd240 + q;
      default: hval = !ng[N-1] ? q : (q == '0) ? '0 : 9'd360 - q;
    endcase
    if (rz[N-1]) hval = '0;
    sval = (sum[N-1] == '0) ? '0 : 8'd255 - sq[N-1];
    ival = 8'((18'(sum[N-1]) * 18'd171) >> 9);
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oDVAL <= 1'b0;
      oH    <= '0;
      oS    <= '0;
      oI    <= '0;
`ifdef RGB2HSI_XY_PASS_EN
      oX    <= '0;
      oY    <= '0;
`endif
    end else begin
      oDVAL <= vld[N-1];
      if (vld[N-1]) begin
        oH <= hval;
        oS <= sval;
        oI <= ival;
`ifdef RGB2HSI_XY_PASS_EN
        oX <= xy[N-1][19:10];
        oY <= xy[N-1][9:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_rgb2hsi_pipe.sv
// tb_rgb2hsi_pipe: directed vectors for the RGB to HSI pipeline.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_rgb2hsi_pipe;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] iR = '0, iG = '0, iB = '0;
  logic       iDVAL = 1'b0;
  logic [8:0] oH;
  logic [7:0] oS, oI;
  logic       oDVAL;

  int passed = 0;
  int total  = 0;

  rgb2hsi_pipe dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iR    (iR),
    .iG    (iG),
    .iB    (iB),
    .iDVAL (iDVAL),
    .oH    (oH),
    .oS    (oS),
    .oI    (oI),
    .oDVAL (oDVAL)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic [8:0] h;
    logic [7:0] s, i;
  } vec_t;

  vec_t vt [12] = '{
    '{8'd255, 8'd0,   8'd0,   9'd0,   8'd255, 8'd85 },
    '{8'd0,   8'd255, 8'd255, 9'd180, 8'd255, 8'd170},
    '{8'd0,   8'd0,   8'd255, 9'd240, 8'd255, 8'd85 },
    '{8'd128, 8'd128, 8'd128, 9'd0,   8'd0,   8'd128},
    '{8'd0,   8'd0,   8'd0,   9'd0,   8'd0,   8'd0  },
    '{8'd255, 8'd0,   8'd1,   9'd0,   8'd255, 8'd85 },
    '{8'd0,   8'd255, 8'd0,   9'd120, 8'd255, 8'd85 },
    '{8'd255, 8'd0,   8'd255, 9'd300, 8'd255, 8'd170},
    '{8'd200, 8'd100, 8'd50,  9'd20,  8'd146, 8'd116},
    '{8'd10,  8'd20,  8'd30,  9'd210, 8'd128, 8'd20 },
    '{8'd255, 8'd255, 8'd0,   9'd60,  8'd255, 8'd170},
    '{8'd50,  8'd100, 8'd200, 9'd220, 8'd146, 8'd116}
  };

  task automatic drive(input int p, input logic v);
    iR    = vt[p].r;
    iG    = vt[p].g;
    iB    = vt[p].b;
    iDVAL = v;
  endtask

  task automatic test_reset;
    iRST_N = 1'b0;
    drive(0, 1'b1);
    repeat (3) @(negedge iCLK);
    total++;
    if ({oDVAL, oH, oS, oI} !== 26'd0) begin
      $display("FAIL reset: got dval=%0b h=%0d s=%0d i=%0d, expected all 0",
               oDVAL, oH, oS, oI);
    end else passed++;
    iRST_N = 1'b1;
    iDVAL  = 1'b0;
  endtask

  task automatic test_vectors;
    for (int k = 0; k < 12; k++) begin
      @(negedge iCLK);
      drive(k, 1'b1);
      @(negedge iCLK);
      iDVAL = 1'b0;
      repeat (8) @(negedge iCLK);
      total++;
      if (oDVAL !== 1'b0) begin
        $display("FAIL vec%0d_early: got dval=%0b, expected 0", k, oDVAL);
      end else passed++;
      @(negedge iCLK);
      total++;
      if ({oDVAL, oH, oS, oI} !== {1'b1, vt[k].h, vt[k].s, vt[k].i}) begin
        $display("FAIL vec%0d: got dval=%0b h=%0d s=%0d i=%0d, expected 1 h=%0d s=%0d i=%0d",
                 k, oDVAL, oH, oS, oI, vt[k].h, vt[k].s, vt[k].i);
      end else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [33:0] in_v;
    int          in_p [34];
    logic [24:0] last;
    logic [25:0] exp;
    in_v = '0;
    last = {vt[11].h, vt[11].s, vt[11].i};
    for (int c = 0; c < 34; c++) begin
      @(negedge iCLK);
      exp = {1'b0, last};
      if (c >= 10 && in_v[c-10]) begin
        last = {vt[in_p[c-10]].h, vt[in_p[c-10]].s, vt[in_p[c-10]].i};
        exp  = {1'b1, last};
      end
      total++;
      if ({oDVAL, oH, oS, oI} !== exp) begin
        $display("FAIL b2b_c%0d: got dval=%0b h=%0d s=%0d i=%0d, expected dval=%0b h=%0d s=%0d i=%0d",
                 c, oDVAL, oH, oS, oI, exp[25], exp[24:16], exp[15:8], exp[7:0]);
      end else passed++;
      in_p[c] = 0;
      if (c < 10) begin
        in_p[c] = c % 12;
        in_v[c] = 1'b1;
      end else if (c >= 13 && c < 23) begin
        in_p[c] = (c - 3) % 12;
        in_v[c] = 1'b1;
      end
      drive(in_p[c], in_v[c]);
    end
  endtask

  task automatic test_reset_midstream;
    logic [25:0] exp;
    for (int c = 0; c < 25; c++) begin
      @(negedge iCLK);
      if (c >= 6) begin
        exp = 26'd0;
        if (c == 19) exp = {1'b1, vt[8].h, vt[8].s, vt[8].i};
        if (c > 19)  exp = {1'b0, vt[8].h, vt[8].s, vt[8].i};
        total++;
        if ({oDVAL, oH, oS, oI} !== exp) begin
          $display("FAIL midrst_c%0d: got dval=%0b h=%0d s=%0d i=%0d, expected dval=%0b h=%0d s=%0d i=%0d",
                   c, oDVAL, oH, oS, oI, exp[25], exp[24:16], exp[15:8], exp[7:0]);
        end else passed++;
      end
      iRST_N = (c != 5);
      if (c <= 5)      drive(c + 1, 1'b1);
      else if (c == 9) drive(8, 1'b1);
      else             drive(0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
